// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: M request channels in, one registered beat out.
// No latency or backpressure of its own; it only groups the handshake signals.
interface arb_mux_if #(
    parameter int N = 32,
    parameter int M = 4
);
    localparam int SW = $clog2(M);

    logic [M-1:0]   in_valid;
    logic [M*N-1:0] in_data;
    logic [M-1:0]   in_last;
    logic [M-1:0]   in_ready;
    logic           out_valid;
    logic [N-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [SW-1:0]  grant_idx;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, grant_idx
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, grant_idx
    );
endinterface

// File: rtl/arb_mux.sv
// Packet-locking M:1 arbiter/mux (fixed or round-robin) into one output slot; 1-cycle latency.
// Backpressure: in_ready is only raised while the slot is empty or draining, so a stall holds everything.
module arb_mux #(
    parameter int N    = 32,
    parameter int M    = 4,
    parameter int MODE = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    arb_mux_if.slave bus
);
    localparam int SW = $clog2(M);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] scan_sel, sel;
    logic          scan_hit, any_req, load_en, xfer, sel_last;
    logic [N-1:0]  sel_data;
    int            scan_idx;

    // First requester in priority order; MODE 1 rotates the start point to rr_ptr.
    always_comb begin
        scan_sel = '0;
        scan_hit = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < M; k++) begin
            if (MODE == 0) scan_idx = k;
            else           scan_idx = (int'(rr_ptr_q) + k) % M;
            if (!scan_hit && bus.in_valid[SW'(scan_idx)]) begin
                scan_hit = 1'b1;
                scan_sel = SW'(scan_idx);
            end
        end
    end

    always_comb begin
        sel      = (state_q == LOCKED) ? lock_ch_q : scan_sel;
        any_req  = (state_q == LOCKED) ? bus.in_valid[lock_ch_q] : scan_hit;
        load_en  = ~bus.out_valid | bus.out_ready;
        xfer     = load_en & any_req;
        sel_last = bus.in_last[sel];
        sel_data = '0;
        bus.in_ready = '0;
        for (int i = 0; i < M; i++) begin
            if (sel == SW'(i)) begin
                sel_data        = bus.in_data[i*N +: N];
                bus.in_ready[i] = xfer;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        if (xfer) begin
            if (state_q == IDLE && !sel_last) begin
                state_d   = LOCKED;
                lock_ch_d = sel;
            end else if (state_q == LOCKED && sel_last) begin
                state_d = IDLE;
            end
            // The pointer only advances on packet boundaries so a lock never shifts fairness.
            if (sel_last) rr_ptr_d = (sel == SW'(M-1)) ? '0 : sel + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.grant_idx <= '0;
        end else if (load_en) begin
            bus.out_valid <= xfer;
            if (xfer) begin
                bus.out_data  <= sel_data;
                bus.out_last  <= sel_last;
                bus.grant_idx <= sel;
            end
        end
    end
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: round-robin, fixed-priority and 2-channel/1-bit instances.
module tb_arb_mux;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    arb_mux_if #(.N(8), .M(4)) rr ();
    arb_mux_if #(.N(8), .M(4)) fp ();
    arb_mux_if #(.N(1), .M(2)) m2 ();

    arb_mux #(.N(8), .M(4), .MODE(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(rr.slave));
    arb_mux #(.N(8), .M(4), .MODE(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(fp.slave));
    arb_mux #(.N(1), .M(2), .MODE(1)) u_m2 (.clk(clk), .rst_n(rst_n), .bus(m2.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        rr.in_valid = '0; rr.in_last = '0; rr.in_data = '0; rr.out_ready = 1'b0;
        fp.in_valid = '0; fp.in_last = '0; fp.in_data = '0; fp.out_ready = 1'b0;
        m2.in_valid = '0; m2.in_last = '0; m2.in_data = '0; m2.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_out_valid", 32'(rr.out_valid), 0);
        chk("rst_out_data",  32'(rr.out_data), 0);
        chk("rst_out_last",  32'(rr.out_last), 0);
        chk("rst_grant_idx", 32'(rr.grant_idx), 0);
        chk("rst_in_ready",  32'(rr.in_ready), 0);
        chk("rst_fp_valid",  32'(fp.out_valid), 0);
        chk("rst_m2_valid",  32'(m2.out_valid), 0);
        @(negedge clk) rst_n = 1'b1;

        // Round-robin rotation with single-beat packets on all channels.
        rr.in_valid = 4'b1111; rr.in_last = 4'b1111; rr.out_ready = 1'b1;
        rr.in_data  = pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1 chk("rr_first_ready", 32'(rr.in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_grant", 32'(rr.grant_idx), i % 4);
            chk("rr_valid", 32'(rr.out_valid), 1);
            chk("rr_data",  32'(rr.out_data), 8'hA0 + (i % 4));
        end

        // Channel 2 packet, with a mid-packet valid drop that must not unlock.
        rr.in_valid = 4'b0100; rr.in_last = 4'b0000;
        rr.in_data  = pack4(8'hA0, 8'hA1, 8'hC0, 8'hA3);
        #1 chk("pkt_ready0", 32'(rr.in_ready), 32'b0100);
        tick();
        chk("pkt_grant0", 32'(rr.grant_idx), 2);
        chk("pkt_data0",  32'(rr.out_data), 8'hC0);
        chk("pkt_last0",  32'(rr.out_last), 0);
        rr.in_valid = 4'b0011;
        #1 chk("lock_drop_ready", 32'(rr.in_ready), 0);
        tick();
        chk("lock_drop_valid", 32'(rr.out_valid), 0);
        chk("lock_drop_hold",  32'(rr.out_data), 8'hC0);
        rr.in_valid = 4'b0111;
        rr.in_data  = pack4(8'hA0, 8'hA1, 8'hC1, 8'hA3);
        #1 chk("pkt_ready1", 32'(rr.in_ready), 32'b0100);
        tick();
        chk("pkt_data1",  32'(rr.out_data), 8'hC1);
        chk("pkt_grant1", 32'(rr.grant_idx), 2);
        rr.in_data = pack4(8'hA0, 8'hA1, 8'hC2, 8'hA3);
        rr.in_last = 4'b0100;
        tick();
        chk("pkt_data2", 32'(rr.out_data), 8'hC2);
        chk("pkt_last2", 32'(rr.out_last), 1);
        rr.in_valid = 4'b0011; rr.in_last = 4'b1111;
        rr.in_data  = pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1 chk("after_pkt_ready", 32'(rr.in_ready), 32'b0001);
        tick();
        chk("after_pkt_grant", 32'(rr.grant_idx), 0);
        chk("after_pkt_data",  32'(rr.out_data), 8'hA0);

        // Output stall for five cycles with requests pending.
        rr.out_ready = 1'b0;
        #1 chk("stall_ready", 32'(rr.in_ready), 0);
        repeat (5) begin
            tick();
            chk("stall_data",  32'(rr.out_data), 8'hA0);
            chk("stall_valid", 32'(rr.out_valid), 1);
            chk("stall_ready", 32'(rr.in_ready), 0);
        end
        rr.out_ready = 1'b1;
        #1 chk("unstall_ready", 32'(rr.in_ready), 32'b0010);
        tick();
        chk("unstall_grant", 32'(rr.grant_idx), 1);
        chk("unstall_data",  32'(rr.out_data), 8'hA1);

        // Asynchronous reset while locked on channel 1 with a beat held.
        rr.in_valid = 4'b0010; rr.in_last = 4'b0000;
        rr.in_data  = pack4(8'hA0, 8'hB1, 8'hA2, 8'hA3);
        #1 chk("lock1_ready", 32'(rr.in_ready), 32'b0010);
        tick();
        chk("lock1_grant", 32'(rr.grant_idx), 1);
        chk("lock1_data",  32'(rr.out_data), 8'hB1);
        rr.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(rr.out_valid), 0);
        chk("arst_data",  32'(rr.out_data), 0);
        chk("arst_grant", 32'(rr.grant_idx), 0);
        #2 rst_n = 1'b1;
        rr.in_valid = 4'b0011; rr.in_last = 4'b1111; rr.out_ready = 1'b1;
        rr.in_data  = pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1;
        chk("post_rst_valid", 32'(rr.out_valid), 0);
        chk("post_rst_ready", 32'(rr.in_ready), 32'b0001);
        tick();
        chk("post_rst_grant", 32'(rr.grant_idx), 0);
        chk("post_rst_data",  32'(rr.out_data), 8'hA0);
        chk("post_rst_last",  32'(rr.out_last), 1);
        rr.in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(rr.out_valid), 0);

        // Fixed priority: channel 1 always beats channel 3.
        fp.in_valid = 4'b1010; fp.in_last = 4'b1111; fp.out_ready = 1'b1;
        fp.in_data  = pack4(8'h50, 8'h51, 8'h52, 8'h53);
        #1 chk("fp_ready", 32'(fp.in_ready), 32'b0010);
        repeat (3) begin
            tick();
            chk("fp_grant", 32'(fp.grant_idx), 1);
            chk("fp_data",  32'(fp.out_data), 8'h51);
            chk("fp_ready", 32'(fp.in_ready), 32'b0010);
        end

        // Two channels, one-bit data: wrap from channel 1 back to 0.
        m2.in_valid = 2'b11; m2.in_last = 2'b11; m2.out_ready = 1'b1;
        m2.in_data  = 2'b10;
        #1 chk("m2_ready", 32'(m2.in_ready), 32'b01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("m2_grant", 32'(m2.grant_idx), i % 2);
            chk("m2_data",  32'(m2.out_data), i % 2);
            chk("m2_valid", 32'(m2.out_valid), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
